// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate strobe, h/v counters, syncs, blanking and
// frame/move pulses, all in the single clk domain.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int MOVE_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        move_tick,
  output logic [7:0]  frame_cnt
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MD      = (MOVE_DIV < 1) ? 1 : MOVE_DIV;
  localparam int MW      = (MD > 1) ? $clog2(MD) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [MW-1:0] MD_LAST  = MW'(MD - 1);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0]   V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0]   HS_BEG   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [MW-1:0] mdiv_q, mdiv_d;
  logic [10:0]   h_q, h_d, v_q, v_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          pix_en_q, pix_en_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic          fs_q, fs_d, mt_q, mt_d;

  // pix_en is registered alongside the counter update it enables, so the
  // strobe and the new hcount/vcount appear in the same cycle.
  always_comb begin
    div_d    = div_q;
    pix_en_d = 1'b0;
    h_d      = h_q;
    v_d      = v_q;
    fs_d     = 1'b0;
    mt_d     = 1'b0;
    fcnt_d   = fcnt_q;
    mdiv_d   = mdiv_q;
    if (div_q == DIV_LAST) begin
      div_d    = '0;
      pix_en_d = 1'b1;
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
      end
    end else begin
      div_d = div_q + DW'(1);
    end
    if (fs_d) begin
      fcnt_d = fcnt_q + 8'd1;
      if (mdiv_q == MD_LAST) begin
        mdiv_d = '0;
        mt_d   = 1'b1;
      end else begin
        mdiv_d = mdiv_q + MW'(1);
      end
    end
    // Decoded from next-state counters so they line up with hcount/vcount.
    hsync_d = !((h_d >= HS_BEG) && (h_d < HS_END));
    vsync_d = !((v_d >= VS_BEG) && (v_d < VS_END));
    blank_d = (h_d >= H_VIS) || (v_d >= V_VIS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      mdiv_q   <= '0;
      h_q      <= '0;
      v_q      <= '0;
      fcnt_q   <= '0;
      pix_en_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blank_q  <= 1'b0;
      fs_q     <= 1'b0;
      mt_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      mdiv_q   <= mdiv_d;
      h_q      <= h_d;
      v_q      <= v_d;
      fcnt_q   <= fcnt_d;
      pix_en_q <= pix_en_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blank_q  <= blank_d;
      fs_q     <= fs_d;
      mt_q     <= mt_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign move_tick   = mt_q;
  assign frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster; a closed-form cycle model
// feeds an expectation queue that is drained after every clock edge.
module tb_vga_timing_gen;
  localparam int CD = 4;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;

  typedef struct packed {
    logic        pe;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic        mt;
    logic [7:0]  fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        pe_a, hs_a, vs_a, bl_a, fs_a, mt_a;
  logic [10:0] h_a, v_a;
  logic [7:0]  fc_a;
  logic        pe_b, hs_b, vs_b, bl_b, fs_b, mt_b;
  logic [10:0] h_b, v_b;
  logic [7:0]  fc_b;

  vga_timing_gen #(.CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MOVE_DIV(2)) u_a (
    .clk(clk), .rst(rst), .pix_en(pe_a), .hcount(h_a), .vcount(v_a), .hsync(hs_a),
    .vsync(vs_a), .blank(bl_a), .frame_start(fs_a), .move_tick(mt_a), .frame_cnt(fc_a));

  vga_timing_gen #(.CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .MOVE_DIV(0)) u_b (
    .clk(clk), .rst(rst), .pix_en(pe_b), .hcount(h_b), .vcount(v_b), .hsync(hs_b),
    .vsync(vs_b), .blank(bl_b), .frame_start(fs_b), .move_tick(mt_b), .frame_cnt(fc_b));

  int   checks = 0;
  int   errors = 0;
  int   t_m    = 0;
  int   cyc    = 0;
  obs_t exp_a_q[$];
  obs_t exp_b_q[$];

  // Expected outputs t clk edges after the last reset edge.
  function automatic obs_t model(input int t, input int md);
    obs_t o;
    int p, fr, hh, vv;
    p  = t / CD;
    fr = p / (HT * VT);
    hh = p % HT;
    vv = (p / HT) % VT;
    o.pe = (t > 0) && (t % CD == 0);
    o.h  = 11'(hh);
    o.v  = 11'(vv);
    o.hs = !((hh >= HV + HF) && (hh < HV + HF + HS));
    o.vs = !((vv >= VV + VF) && (vv < VV + VF + VS));
    o.bl = (hh >= HV) || (vv >= VV);
    o.fs = o.pe && (p % (HT * VT) == 0);
    o.mt = o.fs && (fr % md == 0);
    o.fc = 8'(fr % 256);
    return o;
  endfunction

  task automatic chk(input string tag, input int act, input int req);
    checks++;
    assert (act === req) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, act, req);
    end
  endtask

  task automatic step(input logic r);
    obs_t ea, eb, oa, ob;
    rst = r;
    if (r) t_m = 0; else t_m = t_m + 1;
    exp_a_q.push_back(model(t_m, 2));
    exp_b_q.push_back(model(t_m, 1));
    @(posedge clk);
    #1;
    cyc++;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    oa = {pe_a, h_a, v_a, hs_a, vs_a, bl_a, fs_a, mt_a, fc_a};
    ob = {pe_b, h_b, v_b, hs_b, vs_b, bl_b, fs_b, mt_b, fc_b};
    checks++;
    assert (oa === ea) else begin
      errors++;
      $error("FAIL cyc%0d dut_a: got %h want %h", cyc, oa, ea);
    end
    checks++;
    assert (ob === eb) else begin
      errors++;
      $error("FAIL cyc%0d dut_b: got %h want %h", cyc, ob, eb);
    end
  endtask

  initial begin
    int first_pe, hs_low, hs_fall_h, vs_low, mt_n, mtb_n, fs_n, found;
    int fs_t[$];
    int fc_at_fs[$];

    repeat (3) step(1'b1);

    // Release and run two frames plus a little, recording timing events.
    first_pe = -1; hs_low = 0; hs_fall_h = -1; vs_low = 0;
    for (int i = 1; i <= 2 * FRAME + 8; i++) begin
      step(1'b0);
      if (pe_a && first_pe < 0) first_pe = i;
      if (i <= HT * CD && !hs_a) begin
        if (hs_low == 0) hs_fall_h = int'(h_a);
        hs_low++;
      end
      if (i == HT * CD) chk("vcount_after_line", int'(v_a), 1);
      if (!vs_a) vs_low++;
      if (fs_a) begin
        fs_t.push_back(i);
        fc_at_fs.push_back(int'(fc_a));
      end
    end
    chk("first_pix_en_cycle", first_pe, CD);
    chk("hsync_low_clks", hs_low, HS * CD);
    chk("hsync_fall_hcount", hs_fall_h, HV + HF);
    chk("vsync_low_clks_2frames", vs_low, 2 * VS * HT * CD);
    chk("frame_start_count", fs_t.size(), 2);
    if (fs_t.size() == 2) begin
      chk("frame_start_first", fs_t[0], FRAME);
      chk("frame_start_spacing", fs_t[1] - fs_t[0], FRAME);
      chk("frame_cnt_1", fc_at_fs[0], 1);
      chk("frame_cnt_2", fc_at_fs[1], 2);
    end

    // Frames 3 and 4: move_tick cadence on both instances.
    mt_n = 0; mtb_n = 0; fs_n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0);
      if (fs_a) fs_n++;
      if (mt_a) mt_n++;
      if (mt_b) mtb_n++;
    end
    chk("frames_3_4_starts", fs_n, 2);
    chk("move_tick_div2", mt_n, 1);
    chk("move_tick_div0", mtb_n, 2);

    // Mid-frame reset during vsync low.
    found = 0;
    for (int i = 0; i < FRAME && found == 0; i++) begin
      step(1'b0);
      if (model(t_m, 2).h == 11'd20 && model(t_m, 2).v == 11'd11) found = 1;
    end
    chk("midframe_reached", found, 1);
    chk("midframe_vsync_low", int'(vs_a), 0);
    step(1'b1);
    chk("midframe_rst_fs", int'(fs_a), 0);
    chk("midframe_rst_vsync", int'(vs_a), 1);
    first_pe = -1;
    for (int i = 1; i <= 2 * CD; i++) begin
      step(1'b0);
      if (pe_a && first_pe < 0) first_pe = i;
    end
    chk("restart_first_pix_en", first_pe, CD);

    // Reset landing on the frame wrap edge.
    while (t_m < 2 * FRAME - 1) step(1'b0);
    chk("wrap_h_last", int'(h_a), HT - 1);
    chk("wrap_v_last", int'(v_a), VT - 1);
    chk("wrap_fc_before", int'(fc_a), 1);
    step(1'b1);
    chk("wrap_rst_fs", int'(fs_a), 0);
    chk("wrap_rst_fc", int'(fc_a), 0);
    chk("wrap_rst_h", int'(h_a), 0);
    repeat (2 * CD) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be exactly as follows, one per line (name, default, meaning):
- CLK_DIV, 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate).
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, pixels.
- H_SYNC, 96, horizontal sync width, pixels.
- H_BP, 48, horizontal back porch, pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, lines.
- V_SYNC, 2, vertical sync width, lines.
- V_BP, 33, vertical back porch, lines.
- MOVE_DIV, 2, frames per move_tick; a value of 0 is treated as 1.

REQ-002 Ports SHALL be exactly as follows, one per line (name, direction, width, meaning):
- clk, input, 1, single system clock; all logic on its rising edge.
- rst, input, 1, synchronous reset, active-high.
- pix_en, output, 1, one-clk strobe marking each pixel-clock slot.
- hcount, output, 11, current pixel column, 0..H_TOTAL-1.
- vcount, output, 11, current line, 0..V_TOTAL-1.
- hsync, output, 1, horizontal sync, active-low.
- vsync, output, 1, vertical sync, active-low.
- blank, output, 1, high outside the visible region.
- frame_start, output, 1, one-clk pulse at the start of each frame.
- move_tick, output, 1, one-clk pulse every MOVE_DIV frames; it is the position-update enable for the box-movement logic and replaces any derived slow clock.
- frame_cnt, output, 8, free-running frame counter.

REQ-003 Totals SHALL be H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 by default).

Function
REQ-004 The design SHALL use one clock domain only; no signal is used as a clock and no gated or derived clocks exist.

REQ-005 Pixel divider: a counter of width ceil(log2(CLK_DIV)) SHALL count 0..CLK_DIV-1 and wrap.
- pix_en = 1 exactly when the divider equals CLK_DIV-1.

REQ-006 Counters SHALL change only in cycles where pix_en = 1:
- hcount increments; at H_TOTAL-1 it wraps to 0.
- vcount increments only on an hcount wrap; at V_TOTAL-1 it wraps to 0.

REQ-007 hsync SHALL be 0 iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (656..751 by default).

REQ-008 vsync SHALL be 0 iff V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (490..491 by default).

REQ-009 blank SHALL be 1 iff hcount >= H_VISIBLE or vcount >= V_VISIBLE.

REQ-010 hsync, vsync and blank SHALL be registered from next-state counter values, so that they are consistent with the hcount/vcount presented in the same cycle (zero relative latency, glitch-free).

REQ-011 frame_start SHALL be 1 for exactly one clk cycle when the counters transition from (H_TOTAL-1, V_TOTAL-1) to (0,0), in the same cycle the new values appear.

REQ-012 frame_cnt SHALL increment modulo 256 in the same cycle as frame_start.

REQ-013 A move divider SHALL count frame_start events 0..MOVE_DIV-1:
- move_tick = 1 for one cycle on the frame_start that wraps the divider to 0.
- With MOVE_DIV = 1 (or 0), move_tick equals frame_start.

REQ-014 Period accuracy SHALL hold exactly:
- line = H_TOTAL*CLK_DIV clk cycles (3200 by default);
- frame = H_TOTAL*V_TOTAL*CLK_DIV clk cycles (1,680,000 by default).

REQ-015 pix_en, frame_start and move_tick SHALL never be high for two consecutive cycles when CLK_DIV >= 2.

Reset
REQ-016 While rst = 1 at a clk edge, the block SHALL force all of the following; rst has priority over every other event, including a simultaneous wrap:
- divider = 0, hcount = 0, vcount = 0;
- frame_cnt = 0, move divider = 0;
- hsync = 1, vsync = 1, blank = 0;
- pix_en = 0, frame_start = 0, move_tick = 0.

REQ-017 After rst deasserts, the first pix_en SHALL occur CLK_DIV cycles later, and the first hcount = 1 is presented in the same cycle.

REQ-018 Reset asserted mid-frame (e.g. during vsync low) SHALL restore the REQ-016 values on the next edge, with no pulse on frame_start or move_tick.

REQ-019 No state SHALL depend on initial blocks; reset alone establishes every register value.

Verification
REQ-020 Reset release with default parameters -> pix_en first high on cycle 4; hcount/vcount = 0/0 until then; hsync = vsync = 1; blank = 0.

REQ-021 Run one line -> hsync low for exactly 384 clk, starting when hcount = 656; blank rises at hcount = 640; vcount = 1 after 3200 clk.

REQ-022 Run two frames -> frame_start pulses spaced exactly 1,680,000 clk apart; vsync low for exactly 2 lines (6400 clk) at vcount 490..491; frame_cnt steps 0 -> 1 -> 2.

REQ-023 MOVE_DIV = 2 over four frames -> move_tick on frame_start pulses 2 and 4 only; with MOVE_DIV = 0 -> move_tick on every frame_start.

REQ-024 Assert rst for one cycle at hcount = 700, vcount = 491 -> next cycle shows all REQ-016 values; no frame_start; the timing sequence restarts as in REQ-020.

REQ-025 Counter wrap coincident with rst at (799, 524) -> reset values win; frame_start = 0; frame_cnt = 0.
